// File: rtl/bcd_countdown_timer_pkg.sv
// Shared constants for the MM:SS BCD countdown timer: digit width, per-digit
// maxima and digit field offsets within the 16-bit BCD bus.
package bcd_countdown_timer_pkg;

  localparam int DIGIT_W      = 4;
  localparam int NUM_DIGITS   = 4;
  localparam int SEC_ONES_MAX = 9;
  localparam int SEC_TENS_MAX = 5;
  localparam int MIN_ONES_MAX = 9;

  localparam int SEC_ONES_LSB = 0;
  localparam int SEC_TENS_LSB = 4;
  localparam int MIN_ONES_LSB = 8;
  localparam int MIN_TENS_LSB = 12;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Digit index 0 is sec_ones; the minutes-tens limit is a top-level parameter.
  function automatic digit_t digit_max(input int idx, input int min_tens_max);
    case (idx)
      0:       return digit_t'(SEC_ONES_MAX);
      1:       return digit_t'(SEC_TENS_MAX);
      2:       return digit_t'(MIN_ONES_MAX);
      default: return digit_t'(min_tens_max);
    endcase
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One cascaded BCD down-counting digit: saturating load, decrement on
// borrow-in, wrap to MAX at zero with borrow-out.
module bcd_down_digit
  import bcd_countdown_timer_pkg::*;
#(
  parameter digit_t MAX = 4'd9
) (
  input  logic   CLK,
  input  logic   R_n,
  input  logic   LOAD,
  input  digit_t D,
  input  logic   BIN,
  output digit_t Q,
  output logic   BOUT
);

  always_ff @(posedge CLK or negedge R_n) begin
    if (!R_n)      Q <= '0;
    else if (LOAD) Q <= (D > MAX) ? MAX : D;
    else if (BIN)  Q <= (Q == '0) ? MAX : Q - 4'd1;
  end

  assign BOUT = BIN & (Q == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer: four cascaded down digits, halts at 00:00 and
// pulses DONE for one cycle when the count reaches zero by decrementing.
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int MIN_TENS_MAX = 5
) (
  input  logic        CLK,
  input  logic        R_n,
  input  logic        CE,
  input  logic        RUN,
  input  logic        LOAD,
  input  logic [15:0] PRESET,
  output logic [15:0] Q,
  output logic        ZERO,
  output logic        DONE
);

  digit_t [NUM_DIGITS-1:0] q_d;
  logic   [NUM_DIGITS-1:0] bin;
  logic   [NUM_DIGITS-1:0] bout;
  logic                    dec;
  logic                    unused_bout;

  // ZERO gating keeps the top digit from ever wrapping out of 00:00.
  assign dec         = CE & RUN & ~ZERO & ~LOAD;
  assign bin         = {bout[NUM_DIGITS-2:0], dec};
  assign unused_bout = bout[NUM_DIGITS-1];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_down_digit #(
      .MAX (digit_max(i, MIN_TENS_MAX))
    ) u_digit (
      .CLK  (CLK),
      .R_n  (R_n),
      .LOAD (LOAD),
      .D    (PRESET[i*DIGIT_W +: DIGIT_W]),
      .BIN  (bin[i]),
      .Q    (q_d[i]),
      .BOUT (bout[i])
    );
  end

  assign Q    = q_d;
  assign ZERO = (Q == 16'h0000);

  always_ff @(posedge CLK or negedge R_n) begin
    if (!R_n) DONE <= 1'b0;
    else      DONE <= dec & (Q == 16'h0001);
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: directed scenarios plus a
// randomized run checked against a seconds-based reference model.
module tb_bcd_countdown_timer;

  localparam int MTM = 5;

  logic        CLK = 1'b0;
  logic        R_n = 1'b0;
  logic        CE = 1'b0;
  logic        RUN = 1'b0;
  logic        LOAD = 1'b0;
  logic [15:0] PRESET = 16'h0000;
  logic [15:0] Q;
  logic        ZERO;
  logic        DONE;

  int total = 0;
  int bad   = 0;

  // Reference state: remaining time in plain seconds.
  int m_secs = 0;
  bit m_done = 1'b0;

  bcd_countdown_timer #(.MIN_TENS_MAX(MTM)) dut (
    .CLK    (CLK),
    .R_n    (R_n),
    .CE     (CE),
    .RUN    (RUN),
    .LOAD   (LOAD),
    .PRESET (PRESET),
    .Q      (Q),
    .ZERO   (ZERO),
    .DONE   (DONE)
  );

  always #5 CLK = ~CLK;

  function automatic int clip(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int preset_secs(input logic [15:0] p);
    int mt, mo, st, so;
    mt = clip(int'(p[15:12]), MTM);
    mo = clip(int'(p[11:8]), 9);
    st = clip(int'(p[7:4]), 5);
    so = clip(int'(p[3:0]), 9);
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    logic [15:0] r;
    mm = s / 60;
    ss = s % 60;
    r = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    return r;
  endfunction

  // One clock: model follows the inputs sampled at the edge; exit at negedge.
  task automatic tick();
    @(posedge CLK);
    if (!R_n) begin
      m_secs = 0; m_done = 1'b0;
    end else if (LOAD) begin
      m_secs = preset_secs(PRESET); m_done = 1'b0;
    end else if (CE && RUN && m_secs > 0) begin
      m_done = (m_secs == 1);
      m_secs = m_secs - 1;
    end else begin
      m_done = 1'b0;
    end
    @(negedge CLK);
  endtask

  task automatic load_val(input logic [15:0] p);
    LOAD = 1'b1; PRESET = p; CE = 1'b0;
    tick();
    LOAD = 1'b0;
  endtask

  task automatic test_reset();
    R_n = 1'b0;
    repeat (2) tick();
    total++;
    if (Q !== 16'h0000 || ZERO !== 1'b1 || DONE !== 1'b0) begin
      bad++; $display("FAIL reset_init: Q=%h ZERO=%b DONE=%b want 0000/1/0", Q, ZERO, DONE);
    end
    R_n = 1'b1;
    load_val(16'h1234);
    total++;
    if (Q !== 16'h1234) begin bad++; $display("FAIL reset_preload: Q=%h want 1234", Q); end
    LOAD = 1'b1;
    #2 R_n = 1'b0;
    #1;
    m_secs = 0; m_done = 1'b0;
    total++;
    if (Q !== 16'h0000 || ZERO !== 1'b1 || DONE !== 1'b0) begin
      bad++; $display("FAIL reset_async: Q=%h ZERO=%b DONE=%b want 0000/1/0", Q, ZERO, DONE);
    end
    #1 R_n = 1'b1;
    LOAD = 1'b0; RUN = 1'b1; CE = 1'b1;
    tick();
    CE = 1'b0;
    total++;
    if (Q !== 16'h0000 || DONE !== 1'b0) begin
      bad++; $display("FAIL reset_hold: Q=%h DONE=%b want 0000/0", Q, DONE);
    end
    // Reset just before the final decrement edge must suppress DONE.
    load_val(16'h0001);
    RUN = 1'b1; CE = 1'b1;
    #2 R_n = 1'b0;
    #2 R_n = 1'b1;
    m_secs = 0; m_done = 1'b0;
    tick();
    CE = 1'b0;
    total++;
    if (Q !== 16'h0000 || DONE !== 1'b0) begin
      bad++; $display("FAIL reset_done_suppress: Q=%h DONE=%b want 0000/0", Q, DONE);
    end
  endtask

  task automatic test_borrow();
    load_val(16'h1000);
    RUN = 1'b1; CE = 1'b1; tick(); CE = 1'b0;
    total++;
    if (Q !== 16'h0959) begin bad++; $display("FAIL borrow_first: Q=%h want 0959", Q); end
    tick();
    CE = 1'b1; tick(); CE = 1'b0;
    total++;
    if (Q !== 16'h0958) begin bad++; $display("FAIL borrow_second: Q=%h want 0958", Q); end
    load_val(16'h0100);
    CE = 1'b1; tick(); CE = 1'b0;
    total++;
    if (Q !== 16'h0059) begin bad++; $display("FAIL borrow_min: Q=%h want 0059", Q); end
  endtask

  task automatic test_terminal();
    load_val(16'h0002);
    RUN = 1'b1; CE = 1'b1;
    tick();
    total++;
    if (Q !== 16'h0001 || DONE !== 1'b0 || ZERO !== 1'b0) begin
      bad++; $display("FAIL term_1: Q=%h DONE=%b ZERO=%b want 0001/0/0", Q, DONE, ZERO);
    end
    tick();
    total++;
    if (Q !== 16'h0000 || DONE !== 1'b1 || ZERO !== 1'b1) begin
      bad++; $display("FAIL term_0: Q=%h DONE=%b ZERO=%b want 0000/1/1", Q, DONE, ZERO);
    end
    tick();
    total++;
    if (Q !== 16'h0000 || DONE !== 1'b0) begin
      bad++; $display("FAIL term_hold: Q=%h DONE=%b want 0000/0", Q, DONE);
    end
    CE = 1'b0;
    // Loading zero sets ZERO without a DONE pulse.
    load_val(16'h0000);
    total++;
    if (ZERO !== 1'b1 || DONE !== 1'b0) begin
      bad++; $display("FAIL load_zero: ZERO=%b DONE=%b want 1/0", ZERO, DONE);
    end
  endtask

  task automatic test_simultaneous();
    LOAD = 1'b1; PRESET = 16'h0500; CE = 1'b1; RUN = 1'b1;
    tick();
    LOAD = 1'b0; CE = 1'b0;
    total++;
    if (Q !== 16'h0500) begin bad++; $display("FAIL simul_load: Q=%h want 0500", Q); end
    CE = 1'b1; tick(); CE = 1'b0;
    total++;
    if (Q !== 16'h0459) begin bad++; $display("FAIL simul_next: Q=%h want 0459", Q); end
  endtask

  task automatic test_saturation();
    load_val(16'hFAFA);
    total++;
    if (Q !== 16'h5959) begin bad++; $display("FAIL sat_load: Q=%h want 5959", Q); end
    RUN = 1'b1; CE = 1'b1; tick(); CE = 1'b0;
    total++;
    if (Q !== 16'h5958) begin bad++; $display("FAIL sat_dec: Q=%h want 5958", Q); end
  endtask

  task automatic test_run_gating();
    load_val(16'h0030);
    RUN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      CE = 1'b1; tick(); CE = 1'b0; tick();
    end
    total++;
    if (Q !== 16'h0030) begin bad++; $display("FAIL run_hold: Q=%h want 0030", Q); end
    RUN = 1'b1; CE = 1'b1; tick(); CE = 1'b0;
    total++;
    if (Q !== 16'h0029) begin bad++; $display("FAIL run_resume: Q=%h want 0029", Q); end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    load_val(16'h0005);
    for (int i = 0; i < 400; i++) begin
      LOAD = ($urandom_range(0, 19) == 0);
      PRESET = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 4)) : 16'($urandom);
      CE   = $urandom_range(0, 1);
      RUN  = ($urandom_range(0, 4) != 0);
      tick();
      total++;
      if (Q !== to_bcd(m_secs) || ZERO !== (m_secs == 0) || DONE !== m_done) begin
        bad++; errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: Q=%h ZERO=%b DONE=%b want %h/%b/%b",
                   i, Q, ZERO, DONE, to_bcd(m_secs), (m_secs == 0), m_done);
      end
    end
    LOAD = 1'b0; CE = 1'b0;
  endtask

  initial begin
    test_reset();
    test_borrow();
    test_terminal();
    test_simultaneous();
    test_saturation();
    test_run_gating();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
